// File: rtl/pma_pkg.sv
// Shared PMA types: region attributes, rule records and helpers.
// The rule record uses a fixed 64-bit base/length to line up with cva6_cfg region fields.
package pma_pkg;

   typedef struct packed {
      logic cached;
      logic exec;
      logic nonidem;
   } pma_attr_t;

   localparam int unsigned PmaAddrW = 64;

   typedef struct packed {
      logic [PmaAddrW-1:0] base;
      logic [PmaAddrW-1:0] length;
      pma_attr_t           attr;
   } pma_rule_t;

   localparam pma_attr_t PmaDefaultAttr = '{cached: 1'b0, exec: 1'b0, nonidem: 1'b1};

   // A single rule still needs a 1-bit index.
   function automatic int unsigned pma_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pma_rule_match.sv
// Single-region comparator: base <= addr < base+len.
// The comparison is done one bit wider, so a region running past the top of the address space never wraps.
module pma_rule_match #(
   parameter int unsigned AddrWidth = 64
) (
   input  logic [AddrWidth-1:0] i_base,
   input  logic [AddrWidth-1:0] i_len,
   input  logic [AddrWidth-1:0] i_addr,
   output logic                 o_match
);

   logic [AddrWidth:0] w_end;

   assign w_end   = {1'b0, i_base} + {1'b0, i_len};
   assign o_match = (i_len != '0) && (i_addr >= i_base) && ({1'b0, i_addr} < w_end);

endmodule

// File: rtl/pma_rule_table.sv
// Programmable PMA region table with lockable rules.
// Lookups return a priority hit through a single registered response stage.
module pma_rule_table
   import pma_pkg::*;
#(
   parameter int unsigned    NrRules                 = 4,
   parameter int unsigned    AddrWidth               = 64,
   parameter logic [AddrWidth-1:0] InitBase   [NrRules] = '{default: '0},
   parameter logic [AddrWidth-1:0] InitLength [NrRules] = '{default: '0},
   parameter pma_attr_t      InitAttr   [NrRules]    = '{default: '0},
   parameter pma_attr_t      DefaultAttr             = PmaDefaultAttr
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   // cfg_idx_i is one value wider than strictly needed so that out-of-range indices can be expressed and rejected
   input  logic                               cfg_we_i,
   input  logic [$clog2(NrRules+1)-1:0]       cfg_idx_i,
   input  logic [AddrWidth-1:0]               cfg_base_i,
   input  logic [AddrWidth-1:0]               cfg_len_i,
   input  pma_attr_t                          cfg_attr_i,
   input  logic                               cfg_lock_i,
   output logic                               cfg_err_o,
   output logic [NrRules-1:0]                 lock_o,
   input  logic                               req_valid_i,
   output logic                               req_ready_o,
   input  logic [AddrWidth-1:0]               req_addr_i,
   output logic                               resp_valid_o,
   input  logic                               resp_ready_i,
   output logic                               resp_hit_o,
   output logic [pma_idx_w(NrRules)-1:0]      resp_idx_o,
   output pma_attr_t                          resp_attr_o
);

   localparam int unsigned IdxW    = pma_idx_w(NrRules);
   localparam int unsigned CfgIdxW = $clog2(NrRules+1);
   localparam logic [CfgIdxW-1:0] NrRulesC = CfgIdxW'(NrRules);

   logic [AddrWidth-1:0] r_base [NrRules];
   logic [AddrWidth-1:0] r_len  [NrRules];
   pma_attr_t            r_attr [NrRules];
   logic [NrRules-1:0]   r_lock;
   logic                 r_err;

   logic                 r_valid;
   logic                 r_hit;
   logic [IdxW-1:0]      r_idx;
   pma_attr_t            r_resp_attr;

   logic [NrRules-1:0]   w_match;
   logic                 w_hit;
   logic [IdxW-1:0]      w_idx;
   pma_attr_t            w_attr;
   logic                 w_accept;
   logic                 w_idx_ok;
   logic [IdxW-1:0]      w_widx;
   logic                 w_cfg_bad;

   for (genvar g = 0; g < NrRules; g++) begin : g_match
      pma_rule_match #(
         .AddrWidth(AddrWidth)
      ) u_match (
         .i_base (r_base[g]),
         .i_len  (r_len[g]),
         .i_addr (req_addr_i),
         .o_match(w_match[g])
      );
   end

   // Lowest index wins when regions overlap.
   always_comb begin
      w_hit  = 1'b0;
      w_idx  = '0;
      w_attr = DefaultAttr;
      for (int unsigned i = 0; i < NrRules; i++) begin
         if (w_match[i] && !w_hit) begin
            w_hit  = 1'b1;
            w_idx  = IdxW'(i);
            w_attr = r_attr[i];
         end
      end
   end

   assign req_ready_o = !r_valid || resp_ready_i;
   assign w_accept    = req_valid_i && req_ready_o;

   assign w_idx_ok  = cfg_idx_i < NrRulesC;
   assign w_widx    = cfg_idx_i[IdxW-1:0];
   assign w_cfg_bad = cfg_we_i && (!w_idx_ok || r_lock[w_widx]);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < NrRules; i++) begin
            r_base[i] <= InitBase[i];
            r_len[i]  <= InitLength[i];
            r_attr[i] <= InitAttr[i];
         end
         r_lock <= '0;
         r_err  <= 1'b0;
      end else begin
         r_err <= w_cfg_bad;
         if (cfg_we_i && !w_cfg_bad) begin
            r_base[w_widx] <= cfg_base_i;
            r_len[w_widx]  <= cfg_len_i;
            r_attr[w_widx] <= cfg_attr_i;
            if (cfg_lock_i) begin
               r_lock[w_widx] <= 1'b1;
            end
         end
      end
   end

   // A stalled response holds its payload; only a handshake without a new request drops valid.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid     <= 1'b0;
         r_hit       <= 1'b0;
         r_idx       <= '0;
         r_resp_attr <= DefaultAttr;
      end else if (w_accept) begin
         r_valid     <= 1'b1;
         r_hit       <= w_hit;
         r_idx       <= w_idx;
         r_resp_attr <= w_attr;
      end else if (resp_ready_i) begin
         r_valid <= 1'b0;
      end
   end

   assign cfg_err_o    = r_err;
   assign lock_o       = r_lock;
   assign resp_valid_o = r_valid;
   assign resp_hit_o   = r_hit;
   assign resp_idx_o   = r_idx;
   assign resp_attr_o  = r_resp_attr;

endmodule

// File: tb/tb_pma_rule_table.sv
// Testbench for pma_rule_table: table-driven lookups plus config, lock, stall and reset sequences.
module tb_pma_rule_table;
   import pma_pkg::*;

   typedef struct packed {
      logic       hit;
      logic [1:0] idx;
      pma_attr_t  attr;
   } exp_t;

   typedef struct {
      logic [63:0] addr;
      exp_t        e;
   } vec_t;

   localparam pma_attr_t A_DEF = pma_attr_t'(3'b001);
   localparam pma_attr_t A_C   = pma_attr_t'(3'b100);
   localparam pma_attr_t A_X   = pma_attr_t'(3'b010);
   localparam pma_attr_t A_N   = pma_attr_t'(3'b001);
   localparam pma_attr_t A_CX  = pma_attr_t'(3'b110);

   logic        clk = 1'b0;
   logic        rst_i;
   logic        cfg_we_i;
   logic [2:0]  cfg_idx_i;
   logic [63:0] cfg_base_i;
   logic [63:0] cfg_len_i;
   pma_attr_t   cfg_attr_i;
   logic        cfg_lock_i;
   logic        cfg_err_o;
   logic [3:0]  lock_o;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [63:0] req_addr_i;
   logic        resp_valid_o;
   logic        resp_ready_i;
   logic        resp_hit_o;
   logic [1:0]  resp_idx_o;
   pma_attr_t   resp_attr_o;

   always #5 clk = ~clk;

   pma_rule_table #(
      .NrRules   (4),
      .AddrWidth (64),
      .InitBase  ('{64'h8000_0000, 64'h0, 64'h0, 64'h2000}),
      .InitLength('{64'h4000_0000, 64'h0, 64'h0, 64'h10}),
      .InitAttr  ('{pma_attr_t'(3'b100), pma_attr_t'(3'b000), pma_attr_t'(3'b000), pma_attr_t'(3'b010)})
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .cfg_we_i    (cfg_we_i),
      .cfg_idx_i   (cfg_idx_i),
      .cfg_base_i  (cfg_base_i),
      .cfg_len_i   (cfg_len_i),
      .cfg_attr_i  (cfg_attr_i),
      .cfg_lock_i  (cfg_lock_i),
      .cfg_err_o   (cfg_err_o),
      .lock_o      (lock_o),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_addr_i  (req_addr_i),
      .resp_valid_o(resp_valid_o),
      .resp_ready_i(resp_ready_i),
      .resp_hit_o  (resp_hit_o),
      .resp_idx_o  (resp_idx_o),
      .resp_attr_o (resp_attr_o)
   );

   int unsigned total = 0;
   int unsigned bad   = 0;
   exp_t        q[$];
   logic [63:0] m_base [4];
   logic [63:0] m_len  [4];
   pma_attr_t   m_attr [4];
   logic [3:0]  m_lock;
   logic        exp_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic init_model();
      m_base = '{64'h8000_0000, 64'h0, 64'h0, 64'h2000};
      m_len  = '{64'h4000_0000, 64'h0, 64'h0, 64'h10};
      m_attr = '{A_C, pma_attr_t'(3'b000), pma_attr_t'(3'b000), A_X};
      m_lock = '0;
   endtask

   function automatic exp_t model(input logic [63:0] a);
      exp_t r;
      r = '{hit: 1'b0, idx: 2'd0, attr: A_DEF};
      for (int i = 3; i >= 0; i--) begin
         if (m_len[i] != 0 && a >= m_base[i] && {1'b0, a} < ({1'b0, m_base[i]} + {1'b0, m_len[i]})) begin
            r = '{hit: 1'b1, idx: 2'(i), attr: m_attr[i]};
         end
      end
      return r;
   endfunction

   // One clock: score the outgoing handshake, queue the accepted lookup, update the model, then check cfg_err.
   task automatic cycle(input logic use_exp, input exp_t e);
      exp_t got;
      exp_t want;
      #1;
      if (rst_i) begin
         q.delete();
         init_model();
         exp_err = 1'b0;
      end else begin
         if (resp_valid_o && resp_ready_i) begin
            got = '{hit: resp_hit_o, idx: resp_idx_o, attr: resp_attr_o};
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL resp_extra: got 0x%0h expected no response", got);
            end else begin
               want = q.pop_front();
               check("resp", 64'(got), 64'(want));
            end
         end
         if (req_valid_i && req_ready_o) q.push_back(use_exp ? e : model(req_addr_i));
         exp_err = cfg_we_i && (cfg_idx_i >= 3'd4 || m_lock[cfg_idx_i[1:0]]);
         if (cfg_we_i && !exp_err) begin
            m_base[cfg_idx_i[1:0]] = cfg_base_i;
            m_len[cfg_idx_i[1:0]]  = cfg_len_i;
            m_attr[cfg_idx_i[1:0]] = cfg_attr_i;
            if (cfg_lock_i) m_lock[cfg_idx_i[1:0]] = 1'b1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      check("cfg_err", 64'(cfg_err_o), 64'(exp_err));
   endtask

   task automatic idle();
      cycle(1'b0, '0);
   endtask

   task automatic lookup(input logic [63:0] a, input exp_t e);
      req_valid_i  = 1'b1;
      req_addr_i   = a;
      resp_ready_i = 1'b1;
      cycle(1'b1, e);
      req_valid_i = 1'b0;
   endtask

   task automatic cfg_write(input logic [2:0] idx, input logic [63:0] b, input logic [63:0] l,
                            input pma_attr_t at, input logic lk);
      cfg_we_i   = 1'b1;
      cfg_idx_i  = idx;
      cfg_base_i = b;
      cfg_len_i  = l;
      cfg_attr_i = at;
      cfg_lock_i = lk;
      cycle(1'b0, '0);
      cfg_we_i   = 1'b0;
      cfg_lock_i = 1'b0;
   endtask

   vec_t       vt[12];
   exp_t       snap;
   exp_t       miss;

   initial begin
      miss = '{hit: 1'b0, idx: 2'd0, attr: A_DEF};
      rst_i = 1'b1; cfg_we_i = 1'b0; cfg_idx_i = '0; cfg_base_i = '0; cfg_len_i = '0;
      cfg_attr_i = '0; cfg_lock_i = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; resp_ready_i = 1'b1;
      init_model();
      @(negedge clk);
      idle();
      idle();
      rst_i = 1'b0;

      check("rst_valid", 64'(resp_valid_o), 64'd0);
      check("rst_hit",   64'(resp_hit_o),   64'd0);
      check("rst_idx",   64'(resp_idx_o),   64'd0);
      check("rst_attr",  64'(resp_attr_o),  64'(A_DEF));
      check("rst_lock",  64'(lock_o),       64'd0);

      cfg_write(3'd1, 64'h1_0000, 64'h1_0000, A_X, 1'b0);
      cfg_write(3'd2, 64'h1_8000, 64'h100, A_N, 1'b0);
      cfg_write(3'd3, 64'hFFFF_FFFF_FFFF_FF00, 64'h200, A_CX, 1'b0);

      vt[0]  = '{64'hBFFF_FFFF,           '{1'b1, 2'd0, A_C}};
      vt[1]  = '{64'hC000_0000,           miss};
      vt[2]  = '{64'h8000_0000,           '{1'b1, 2'd0, A_C}};
      vt[3]  = '{64'h7FFF_FFFF,           miss};
      vt[4]  = '{64'h1_8010,              '{1'b1, 2'd1, A_X}};
      vt[5]  = '{64'h1_0000,              '{1'b1, 2'd1, A_X}};
      vt[6]  = '{64'h2_0000,              miss};
      vt[7]  = '{64'h10,                  miss};
      vt[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, '{1'b1, 2'd3, A_CX}};
      vt[9]  = '{64'hFFFF_FFFF_FFFF_FF00, '{1'b1, 2'd3, A_CX}};
      vt[10] = '{64'hFFFF_FFFF_FFFF_FEFF, miss};
      vt[11] = '{64'h2000,                miss};
      for (int i = 0; i < 12; i++) lookup(vt[i].addr, vt[i].e);
      idle();

      // Lock rule 2, then try to rewrite it and to write past the table.
      cfg_write(3'd2, 64'h5000, 64'h10, A_C, 1'b1);
      check("lock_set", 64'(lock_o), 64'h4);
      lookup(64'h5008, '{1'b1, 2'd2, A_C});
      cfg_write(3'd2, 64'h6000, 64'h10, A_X, 1'b0);
      idle();
      lookup(64'h6008, miss);
      lookup(64'h5008, '{1'b1, 2'd2, A_C});
      cfg_write(3'd5, 64'h7000, 64'h10, A_X, 1'b0);
      cfg_write(3'd4, 64'h7000, 64'h10, A_X, 1'b0);
      lookup(64'h7008, miss);
      check("lock_keep", 64'(lock_o), 64'h4);

      // Lookup in the same cycle as the write sees the old table.
      cfg_we_i = 1'b1; cfg_idx_i = 3'd1; cfg_base_i = 64'h9000; cfg_len_i = 64'h10;
      cfg_attr_i = A_X; cfg_lock_i = 1'b0;
      req_valid_i = 1'b1; req_addr_i = 64'h9004; resp_ready_i = 1'b1;
      cycle(1'b1, miss);
      cfg_we_i = 1'b0; req_valid_i = 1'b0;
      lookup(64'h9004, '{1'b1, 2'd1, A_X});
      idle();

      // Stall for three cycles with a second request waiting.
      req_valid_i = 1'b1; req_addr_i = 64'h8000_0010; resp_ready_i = 1'b1;
      cycle(1'b1, '{1'b1, 2'd0, A_C});
      req_addr_i = 64'h9008; resp_ready_i = 1'b0;
      #1;
      snap = '{hit: resp_hit_o, idx: resp_idx_o, attr: resp_attr_o};
      check("stall_start_valid", 64'(resp_valid_o), 64'd1);
      for (int i = 0; i < 3; i++) begin
         idle();
         check("stall_ready", 64'(req_ready_o), 64'd0);
         check("stall_valid", 64'(resp_valid_o), 64'd1);
         check("stall_hold", 64'({resp_hit_o, resp_idx_o, resp_attr_o}), 64'(snap));
      end
      resp_ready_i = 1'b1;
      cycle(1'b1, '{1'b1, 2'd1, A_X});
      req_valid_i = 1'b0;
      idle();
      check("stall_drained", 64'(q.size()), 64'd0);
      check("stall_idle_valid", 64'(resp_valid_o), 64'd0);

      // Reset while a response is stalled.
      req_valid_i = 1'b1; req_addr_i = 64'h8000_0000; resp_ready_i = 1'b1;
      cycle(1'b1, '{1'b1, 2'd0, A_C});
      req_valid_i = 1'b0; resp_ready_i = 1'b0;
      idle();
      check("pre_rst_valid", 64'(resp_valid_o), 64'd1);
      rst_i = 1'b1;
      idle();
      rst_i = 1'b0;
      #1;
      check("post_rst_valid", 64'(resp_valid_o), 64'd0);
      check("post_rst_ready", 64'(req_ready_o),  64'd1);
      check("post_rst_lock",  64'(lock_o),       64'd0);
      check("post_rst_resp",  64'({resp_hit_o, resp_idx_o, resp_attr_o}), 64'(miss));
      lookup(64'h8000_0000, '{1'b1, 2'd0, A_C});
      lookup(64'h2008,      '{1'b1, 2'd3, A_X});
      lookup(64'h5008,      miss);
      lookup(64'h9004,      miss);
      cfg_write(3'd2, 64'h5000, 64'h10, A_N, 1'b0);
      lookup(64'h5008,      '{1'b1, 2'd2, A_N});

      req_valid_i = 1'b0; resp_ready_i = 1'b1;
      for (int i = 0; i < 10 && q.size() > 0; i++) idle();
      check("final_drain", 64'(q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
